// File: rtl/lru_tracker.sv
// -----------------------------------------------------------------------------
// lru_tracker
//   True-LRU replacement tracker for a SETS x WAYS set-associative cache.
//   Each set keeps a recency-ordered list of way indices (position 0 = MRU,
//   position WAYS-1 = LRU) plus a per-way valid bit. One touch / fill /
//   invalidate / query is accepted per cycle, and its response is registered
//   one cycle later. A flush sweeps every set back to its reset contents, one
//   set per cycle, while new requests are refused.
//
//   Optional build macro: LRU_STATS_EN
//     Adds saturating 32-bit fill and eviction counters (stat_fill_o,
//     stat_evict_o). These counters are cleared by reset but not by flush.
// -----------------------------------------------------------------------------
module lru_tracker #(
   parameter int WAYS     = 4,
   parameter int SETS     = 64,
   parameter int WAY_BITS = $clog2(WAYS),
   parameter int SET_BITS = (SETS > 1) ? $clog2(SETS) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [1:0]          req_op_i,
   input  logic [SET_BITS-1:0] req_set_i,
   input  logic [WAY_BITS-1:0] req_way_i,
   input  logic                flush_i,
   output logic                rsp_valid_o,
   output logic [SET_BITS-1:0] rsp_set_o,
   output logic [WAY_BITS-1:0] rsp_way_o,
   output logic                rsp_evict_o
`ifdef LRU_STATS_EN
   ,
   output logic [31:0]         stat_fill_o,
   output logic [31:0]         stat_evict_o
`endif
);

   localparam logic [1:0] OP_TOUCH = 2'b00;
   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_INVAL = 2'b10;
   localparam logic [1:0] OP_QUERY = 2'b11;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   localparam int unsigned SETS_U = SETS;

   typedef logic [WAY_BITS-1:0]            way_t;
   typedef logic [WAYS-1:0][WAY_BITS-1:0]  order_t;

   // The reset/flush contents of one set's order list: position p holds way p.
   function automatic order_t reset_order();
      order_t r;
      for (int p = 0; p < WAYS; p++) begin
         r[p] = way_t'(p);
      end
      return r;
   endfunction

   // State
   logic [0:0]          state_q, state_d;
   logic [SET_BITS-1:0] flush_cnt_q, flush_cnt_d;
   order_t              order_q [SETS];
   order_t              order_d [SETS];
   logic [WAYS-1:0]     valid_q [SETS];
   logic [WAYS-1:0]     valid_d [SETS];
   logic                rsp_valid_q, rsp_valid_d;
   logic [SET_BITS-1:0] rsp_set_q, rsp_set_d;
   way_t                rsp_way_q, rsp_way_d;
   logic                rsp_evict_q, rsp_evict_d;

   // Addressed-set view and its candidate updates
   logic                accept;
   logic                set_in_range;
   logic [SET_BITS-1:0] set_idx;
   order_t              cur_order;
   logic [WAYS-1:0]     cur_valid;
   way_t                victim;
   way_t                tgt_way;
   int                  tgt_pos;
   order_t              mru_order;
   order_t              lru_order;

   assign req_ready_o = (state_q == ST_IDLE);
   assign accept      = req_valid_i && req_ready_o;

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_set_o   = rsp_set_q;
   assign rsp_way_o   = rsp_way_q;
   assign rsp_evict_o = rsp_evict_q;

`ifdef LRU_STATS_EN
   logic [31:0] stat_fill_q, stat_fill_d;
   logic [31:0] stat_evict_q, stat_evict_d;

   assign stat_fill_o  = stat_fill_q;
   assign stat_evict_o = stat_evict_q;
`endif

   // Read the addressed set and compute its victim plus move-to-MRU / move-to-LRU orders.
   always_comb begin
      // NOTE: every variable gets a default at the top of an always_comb, so no path leaves it unassigned and no latch is inferred.
      set_in_range = (32'(req_set_i) < SETS_U);
      set_idx      = set_in_range ? req_set_i : '0;
      cur_order    = order_q[set_idx];
      cur_valid    = valid_q[set_idx];

      // Lowest-index invalid way wins; otherwise the LRU entry.
      victim = cur_order[WAYS-1];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!cur_valid[w]) begin
            victim = way_t'(w);
         end
      end

      tgt_way = (req_op_i == OP_FILL) ? victim : req_way_i;
      tgt_pos = 0;
      for (int p = 0; p < WAYS; p++) begin
         if (cur_order[p] == tgt_way) begin
            tgt_pos = p;
         end
      end

      // Target to MRU; entries that were above it slide one step toward LRU.
      mru_order    = cur_order;
      mru_order[0] = tgt_way;
      for (int p = 1; p < WAYS; p++) begin
         if (p <= tgt_pos) begin
            mru_order[p] = cur_order[p-1];
         end
      end

      // Target to LRU; entries that were below it slide one step toward MRU.
      lru_order         = cur_order;
      lru_order[WAYS-1] = tgt_way;
      for (int p = 0; p < WAYS - 1; p++) begin
         if (p >= tgt_pos) begin
            lru_order[p] = cur_order[p+1];
         end
      end
   end

   // Next-state: request write-back, response registers, flush sweep FSM.
   always_comb begin
      order_d     = order_q;
      valid_d     = valid_q;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      rsp_valid_d = 1'b0;
      rsp_set_d   = rsp_set_q;
      rsp_way_d   = rsp_way_q;
      rsp_evict_d = rsp_evict_q;

      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_set_d   = req_set_i;
         rsp_way_d   = '0;
         rsp_evict_d = 1'b0;
         if (set_in_range) begin
            case (req_op_i)
               OP_TOUCH: begin
                  order_d[set_idx] = mru_order;
                  rsp_way_d        = req_way_i;
               end
               OP_FILL: begin
                  order_d[set_idx]         = mru_order;
                  valid_d[set_idx][victim] = 1'b1;
                  rsp_way_d                = victim;
                  rsp_evict_d              = cur_valid[victim];
               end
               OP_INVAL: begin
                  order_d[set_idx]            = lru_order;
                  valid_d[set_idx][req_way_i] = 1'b0;
                  rsp_way_d                   = req_way_i;
               end
               default: begin
                  rsp_way_d   = victim;
                  rsp_evict_d = cur_valid[victim];
               end
            endcase
         end
      end

      // No request is accepted in FLUSH, so the sweep never collides with a write-back.
      case (state_q)
         ST_IDLE: begin
            if (flush_i) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
            end
         end
         default: begin
            order_d[flush_cnt_q] = reset_order();
            valid_d[flush_cnt_q] = '0;
            if (32'(flush_cnt_q) == SETS_U - 1) begin
               state_d = ST_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q + SET_BITS'(1);
            end
         end
      endcase
   end

`ifdef LRU_STATS_EN
   // Saturating counters of accepted fills and of fills that evicted valid data.
   always_comb begin
      stat_fill_d  = stat_fill_q;
      stat_evict_d = stat_evict_q;
      if (accept && (req_op_i == OP_FILL)) begin
         if (stat_fill_q != 32'hFFFF_FFFF) begin
            stat_fill_d = stat_fill_q + 32'd1;
         end
         if (rsp_evict_d && (stat_evict_q != 32'hFFFF_FFFF)) begin
            stat_evict_d = stat_evict_q + 32'd1;
         end
      end
   end
`endif

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= '0;
         // NOTE: the order/valid arrays are plain flops rather than a RAM, because every set must leave reset with a defined order list.
         for (int s = 0; s < SETS; s++) begin
            order_q[s] <= reset_order();
            valid_q[s] <= '0;
         end
         rsp_valid_q <= 1'b0;
         rsp_set_q   <= '0;
         rsp_way_q   <= '0;
         rsp_evict_q <= 1'b0;
`ifdef LRU_STATS_EN
         stat_fill_q  <= '0;
         stat_evict_q <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge inputs.
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         order_q     <= order_d;
         valid_q     <= valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_set_q   <= rsp_set_d;
         rsp_way_q   <= rsp_way_d;
         rsp_evict_q <= rsp_evict_d;
`ifdef LRU_STATS_EN
         stat_fill_q  <= stat_fill_d;
         stat_evict_q <= stat_evict_d;
`endif
      end
   end

endmodule

// File: tb/tb_lru_tracker.sv
// -----------------------------------------------------------------------------
// tb_lru_tracker
//   Directed testbench for lru_tracker (WAYS=4, SETS=64). Each task drives a
//   scenario and compares the registered response against hand-derived values.
//   Inputs change on the falling edge. Outputs are sampled 1 ns after the
//   rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lru_tracker;

   localparam logic [1:0] OP_TOUCH = 2'b00;
   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_INVAL = 2'b10;
   localparam logic [1:0] OP_QUERY = 2'b11;

   logic       clk_i;
   logic       rst_i;
   logic       req_valid_i;
   logic       req_ready_o;
   logic [1:0] req_op_i;
   logic [5:0] req_set_i;
   logic [1:0] req_way_i;
   logic       flush_i;
   logic       rsp_valid_o;
   logic [5:0] rsp_set_o;
   logic [1:0] rsp_way_o;
   logic       rsp_evict_o;
`ifdef LRU_STATS_EN
   logic [31:0] stat_fill_o;
   logic [31:0] stat_evict_o;
`endif

   int checks   = 0;
   int failures = 0;

   lru_tracker #(.WAYS(4), .SETS(64)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_op_i    (req_op_i),
      .req_set_i   (req_set_i),
      .req_way_i   (req_way_i),
      .flush_i     (flush_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_set_o   (rsp_set_o),
      .rsp_way_o   (rsp_way_o),
      .rsp_evict_o (rsp_evict_o)
`ifdef LRU_STATS_EN
      ,
      .stat_fill_o  (stat_fill_o),
      .stat_evict_o (stat_evict_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Present one request on the falling edge, then return 1 ns after the capturing edge.
   task automatic drive(input logic [1:0] op, input int set, input int way);
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_op_i    = op;
      req_set_i   = 6'(set);
      req_way_i   = 2'(way);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      @(negedge clk_i);
      req_valid_i = 1'b0;
      flush_i     = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] got;
      logic [9:0]  rsp;
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      req_op_i    = OP_TOUCH;
      req_set_i   = '0;
      req_way_i   = '0;
      flush_i     = 1'b0;
      #2;
      got = {req_ready_o, rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (got !== 11'h400) begin
         failures++;
         $display("FAIL reset_state: got=%h expected=%h", got, 11'h400);
      end
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      drive(OP_QUERY, 5, 0);
      rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (rsp !== {1'b1, 6'd5, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_query: got=%h expected=%h", rsp, {1'b1, 6'd5, 2'd0, 1'b0});
      end
      idle();
      @(posedge clk_i);
      #1;
      rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (rsp !== {1'b0, 6'd5, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL rsp_hold: got=%h expected=%h", rsp, {1'b0, 6'd5, 2'd0, 1'b0});
      end
   endtask

   task automatic test_fill_sequence();
      int         ew [5] = '{0, 1, 2, 3, 0};
      int         ee [5] = '{0, 0, 0, 0, 1};
      logic [9:0] rsp;
      logic [9:0] exp;
      for (int i = 0; i < 5; i++) begin
         drive(OP_FILL, 3, 0);
         rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
         exp = {1'b1, 6'd3, 2'(ew[i]), 1'(ee[i])};
         checks++;
         if (rsp !== exp) begin
            failures++;
            $display("FAIL fill_seq[%0d]: got=%h expected=%h", i, rsp, exp);
         end
      end
`ifdef LRU_STATS_EN
      checks++;
      if (stat_fill_o !== 32'd5 || stat_evict_o !== 32'd1) begin
         failures++;
         $display("FAIL stats: got fill=%0d evict=%0d expected fill=5 evict=1", stat_fill_o, stat_evict_o);
      end
`endif
      idle();
   endtask

   task automatic test_touch_query();
      logic [1:0] ops [7] = '{OP_FILL, OP_FILL, OP_FILL, OP_FILL, OP_TOUCH, OP_TOUCH, OP_QUERY};
      int         way [7] = '{0, 0, 0, 0, 0, 1, 0};
      int         ew  [7] = '{0, 1, 2, 3, 0, 1, 2};
      int         ee  [7] = '{0, 0, 0, 0, 0, 0, 1};
      logic [9:0] rsp;
      logic [9:0] exp;
      for (int i = 0; i < 7; i++) begin
         drive(ops[i], 4, way[i]);
         rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
         exp = {1'b1, 6'd4, 2'(ew[i]), 1'(ee[i])};
         checks++;
         if (rsp !== exp) begin
            failures++;
            $display("FAIL touch_query[%0d]: got=%h expected=%h", i, rsp, exp);
         end
      end
      idle();
   endtask

   task automatic test_invalidate_fill();
      int         set [22] = '{7, 7, 7, 7, 7, 7, 7,
                               10, 10, 10, 10, 10, 10, 10, 10,
                               11, 11, 11, 11, 11, 11, 11};
      logic [1:0] ops [22] = '{OP_FILL, OP_FILL, OP_FILL, OP_FILL, OP_INVAL, OP_FILL, OP_QUERY,
                               OP_FILL, OP_FILL, OP_FILL, OP_FILL, OP_INVAL, OP_TOUCH, OP_FILL, OP_QUERY,
                               OP_FILL, OP_FILL, OP_FILL, OP_FILL, OP_INVAL, OP_FILL, OP_QUERY};
      int         way [22] = '{0, 0, 0, 0, 2, 0, 0,
                               0, 0, 0, 0, 1, 1, 0, 0,
                               0, 0, 0, 0, 3, 0, 0};
      int         ew  [22] = '{0, 1, 2, 3, 2, 2, 0,
                               0, 1, 2, 3, 1, 1, 1, 0,
                               0, 1, 2, 3, 3, 3, 0};
      int         ee  [22] = '{0, 0, 0, 0, 0, 0, 1,
                               0, 0, 0, 0, 0, 0, 0, 1,
                               0, 0, 0, 0, 0, 0, 1};
      logic [9:0] rsp;
      logic [9:0] exp;
      for (int i = 0; i < 22; i++) begin
         drive(ops[i], set[i], way[i]);
         rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
         exp = {1'b1, 6'(set[i]), 2'(ew[i]), 1'(ee[i])};
         checks++;
         if (rsp !== exp) begin
            failures++;
            $display("FAIL inval_fill[%0d]: got=%h expected=%h", i, rsp, exp);
         end
      end
      idle();
   endtask

   task automatic test_flush();
      logic [9:0] rsp;
      int         busy_cycles;
      bit         done;
      drive(OP_FILL, 0, 0);
      drive(OP_FILL, 63, 0);
      rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (rsp !== {1'b1, 6'd63, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL flush_prefill: got=%h expected=%h", rsp, {1'b1, 6'd63, 2'd0, 1'b0});
      end

      // Flush pulse with a query in the same cycle; req_valid_i then stays high throughout.
      @(negedge clk_i);
      flush_i     = 1'b1;
      req_valid_i = 1'b1;
      req_op_i    = OP_QUERY;
      req_set_i   = 6'd63;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (rsp !== {1'b1, 6'd63, 2'd1, 1'b0}) begin
         failures++;
         $display("FAIL flush_same_cycle_req: got=%h expected=%h", rsp, {1'b1, 6'd63, 2'd1, 1'b0});
      end

      busy_cycles = req_ready_o ? 0 : 1;
      done        = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk_i);
         #1;
         if (req_ready_o) begin
            done = 1'b1;
         end else begin
            busy_cycles++;
            checks++;
            if (rsp_valid_o !== 1'b0) begin
               failures++;
               $display("FAIL flush_no_rsp[%0d]: got=%b expected=0", i, rsp_valid_o);
            end
         end
      end
      checks++;
      if (busy_cycles !== 64) begin
         failures++;
         $display("FAIL flush_length: got=%0d expected=64", busy_cycles);
      end
      checks++;
      if (rsp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_drop_last: got=%b expected=0", rsp_valid_o);
      end

      @(posedge clk_i);
      #1;
      rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (rsp !== {1'b1, 6'd63, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL flush_query63: got=%h expected=%h", rsp, {1'b1, 6'd63, 2'd0, 1'b0});
      end
      drive(OP_QUERY, 3, 0);
      rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (rsp !== {1'b1, 6'd3, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL flush_query3: got=%h expected=%h", rsp, {1'b1, 6'd3, 2'd0, 1'b0});
      end
      idle();
   endtask

   task automatic test_async_reset();
      logic [9:0]  rsp;
      logic [10:0] got;
      drive(OP_FILL, 2, 0);
      @(negedge clk_i);
      flush_i     = 1'b1;
      req_valid_i = 1'b1;
      req_op_i    = OP_QUERY;
      req_set_i   = 6'd2;
      @(posedge clk_i);
      #1;
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      got = {req_ready_o, rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (got !== {1'b0, 1'b1, 6'd2, 2'd1, 1'b0}) begin
         failures++;
         $display("FAIL pre_reset_state: got=%h expected=%h", got, {1'b0, 1'b1, 6'd2, 2'd1, 1'b0});
      end

      // Reset lands between clock edges; outputs must clear without waiting for one.
      #2;
      rst_i = 1'b1;
      #1;
      got = {req_ready_o, rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (got !== 11'h400) begin
         failures++;
         $display("FAIL async_reset: got=%h expected=%h", got, 11'h400);
      end
`ifdef LRU_STATS_EN
      checks++;
      if (stat_fill_o !== 32'd0 || stat_evict_o !== 32'd0) begin
         failures++;
         $display("FAIL stats_reset: got fill=%0d evict=%0d expected 0", stat_fill_o, stat_evict_o);
      end
`endif
      @(negedge clk_i);
      rst_i = 1'b0;

      drive(OP_QUERY, 2, 0);
      rsp = {rsp_valid_o, rsp_set_o, rsp_way_o, rsp_evict_o};
      checks++;
      if (rsp !== {1'b1, 6'd2, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL post_reset_query: got=%h expected=%h", rsp, {1'b1, 6'd2, 2'd0, 1'b0});
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fill_sequence();
      test_touch_query();
      test_invalidate_fill();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
